// File: rtl/cpc_rom_bootloader.sv
// Streams 32-bit boot words from the control module into SRAM, one byte per write, MSB first.
// Optional feature: define ROM_CHECKSUM_EN to accumulate a 16-bit additive checksum of written bytes.
module cpc_rom_bootloader #(
    parameter int TOTAL_BYTES = 49152,
    parameter int ADDR_W      = 19,
    parameter int BASE_ADDR   = 0,
    parameter int WR_CYCLES   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       host_bootdata,
    input  logic              host_bootdata_ack,
    output logic              host_bootdata_req,
    output logic [ADDR_W-1:0] romwrite_addr,
    output logic [7:0]        romwrite_data,
    output logic              romwrite_wr,
    output logic              romwrite_done,
    output logic [15:0]       rom_checksum
);

    localparam int CNT_W = $clog2(TOTAL_BYTES + 1);
    localparam int WC_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_REQ,
        S_SETUP,
        S_WRITE,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic [7:0]        data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic              done_q, done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= ADDR_W'(BASE_ADDR);
            cnt_q   <= '0;
            wcnt_q  <= '0;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        data_d  = data_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_REQ: begin
                // req is registered, so an ack in the cycle after reset release is ignored
                if (req_q && host_bootdata_ack) begin
                    word_d  = host_bootdata;
                    idx_d   = 2'd0;
                    data_d  = host_bootdata[31:24];
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                wcnt_d  = '0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wcnt_q == WC_W'(WR_CYCLES - 1)) begin
                    state_d = S_NEXT;
                end else begin
                    wcnt_d = wcnt_q + WC_W'(1);
                end
            end
            S_NEXT: begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(TOTAL_BYTES - 1)) begin
                    state_d = S_DONE;
                end else if (idx_q == 2'd3) begin
                    state_d = S_REQ;
                end else begin
                    // word is kept left-aligned so the next byte is always bits [23:16]
                    idx_d   = idx_q + 2'd1;
                    word_d  = {word_q[23:0], 8'h00};
                    data_d  = word_q[23:16];
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        req_d  = (state_d == S_REQ);
        wr_d   = (state_d == S_WRITE);
        done_d = (state_d == S_DONE);
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= 16'h0000;
        end else begin
            csum_q <= csum_d;
        end
    end

    always_comb begin
        csum_d = csum_q;
        if (state_q == S_NEXT) begin
            csum_d = csum_q + {8'h00, data_q};
        end
    end

    assign rom_checksum = csum_q;
`else
    assign rom_checksum = 16'h0000;
`endif

    assign host_bootdata_req = req_q;
    assign romwrite_addr     = addr_q;
    assign romwrite_data     = data_q;
    assign romwrite_wr       = wr_q;
    assign romwrite_done     = done_q;

endmodule
